// File: rtl/bf_tape_arbiter.sv
// bf_tape_arbiter: shares the single-port tape RAM between the interpreter core and a host port
module bf_tape_arbiter #(
    parameter int M        = 8,
    parameter int W        = 8,
    parameter int HOST_MAX = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_core_req,
    input  logic         i_core_we,
    input  logic [M-1:0] i_core_addr,
    input  logic [W-1:0] i_core_wdata,
    output logic         o_core_gnt,
    output logic         o_core_rvalid,
    output logic [W-1:0] o_core_rdata,
    input  logic         i_host_req,
    input  logic         i_host_we,
    input  logic [M-1:0] i_host_addr,
    input  logic [W-1:0] i_host_wdata,
    output logic         o_host_gnt,
    output logic         o_host_rvalid,
    output logic [W-1:0] o_host_rdata,
    output logic         o_mem_en,
    output logic         o_mem_we,
    output logic [M-1:0] o_mem_addr,
    output logic [W-1:0] o_mem_wdata,
    input  logic [W-1:0] i_mem_rdata,
    output logic         o_starve
);
    localparam int CW = $clog2(HOST_MAX + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(HOST_MAX);

    logic [CW-1:0] r_wait_cnt;
    logic          r_rd_valid;
    logic          r_rd_host;
    logic [W-1:0]  r_core_rdata;
    logic [W-1:0]  r_host_rdata;
    logic          w_force;
    logic          w_host_gnt;
    logic          w_core_gnt;

    // Priority grant: core first unless the host has waited HOST_MAX cycles
    always_comb begin
        w_force     = i_host_req & (r_wait_cnt == MAX_CNT);
        w_host_gnt  = ~i_reset & i_host_req & (w_force | ~i_core_req);
        w_core_gnt  = ~i_reset & i_core_req & ~w_host_gnt;
        o_host_gnt  = w_host_gnt;
        o_core_gnt  = w_core_gnt;
        o_starve    = ~i_reset & w_force;
        o_mem_en    = w_host_gnt | w_core_gnt;
        o_mem_we    = w_host_gnt ? i_host_we    : w_core_gnt ? i_core_we    : 1'b0;
        o_mem_addr  = w_host_gnt ? i_host_addr  : w_core_gnt ? i_core_addr  : '0;
        o_mem_wdata = w_host_gnt ? i_host_wdata : w_core_gnt ? i_core_wdata : '0;
    end

    // Read return steering: RAM data passes straight through while valid, else last value held
    always_comb begin
        o_core_rvalid = ~i_reset & r_rd_valid & ~r_rd_host;
        o_host_rvalid = ~i_reset & r_rd_valid & r_rd_host;
        o_core_rdata  = o_core_rvalid ? i_mem_rdata : r_core_rdata;
        o_host_rdata  = o_host_rvalid ? i_mem_rdata : r_host_rdata;
    end

    // Host wait counter, read-return tag and held read data
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wait_cnt   <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_host    <= 1'b0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            r_wait_cnt   <= (w_host_gnt | ~i_host_req) ? '0 :
                            (r_wait_cnt == MAX_CNT) ? MAX_CNT : r_wait_cnt + 1'b1;
            r_rd_valid   <= o_mem_en & ~o_mem_we;
            r_rd_host    <= w_host_gnt;
            r_core_rdata <= o_core_rdata;
            r_host_rdata <= o_host_rdata;
        end
    end
endmodule

// File: tb/tb_bf_tape_arbiter.sv
// tb_bf_tape_arbiter: directed scenarios plus randomized traffic against a behavioural tape model
module tb_bf_tape_arbiter;
    localparam int M  = 8;
    localparam int W  = 8;
    localparam int HM = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         core_req, core_we, host_req, host_we;
    logic [M-1:0] core_addr, host_addr;
    logic [W-1:0] core_wdata, host_wdata;
    logic         core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [W-1:0] core_rdata, host_rdata;
    logic         mem_en, mem_we, starve;
    logic [M-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] ram    [2**M];
    logic [W-1:0] shadow [2**M];

    int           m_denied;
    bit           m_pc, m_ph;
    logic [W-1:0] m_pd, m_lc, m_lh;

    always #5 clk = ~clk;

    bf_tape_arbiter #(.M(M), .W(W), .HOST_MAX(HM)) dut (
        .i_clock(clk), .i_reset(reset),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_starve(starve)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic bit exp_hg();
        return !reset && host_req && (m_denied >= HM || !core_req);
    endfunction

    function automatic bit exp_cg();
        return !reset && core_req && !exp_hg();
    endfunction

    task automatic drive(input bit cr, input bit cw, input logic [M-1:0] ca, input logic [W-1:0] cd,
                         input bit hr, input bit hw, input logic [M-1:0] ha, input logic [W-1:0] hd);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic poke(input logic [M-1:0] a, input logic [W-1:0] d);
        ram[a] = d;
        shadow[a] = d;
    endtask

    task automatic tick();
        bit hg, cg;
        hg = exp_hg();
        cg = exp_cg();
        if (reset) begin
            m_denied = 0; m_pc = 0; m_ph = 0; m_lc = '0; m_lh = '0;
        end else begin
            if (m_pc) m_lc = m_pd;
            if (m_ph) m_lh = m_pd;
            m_pc = cg && !core_we;
            m_ph = hg && !host_we;
            if (m_pc) m_pd = shadow[core_addr];
            if (m_ph) m_pd = shadow[host_addr];
            if (cg && core_we) shadow[core_addr] = core_wdata;
            if (hg && host_we) shadow[host_addr] = host_wdata;
            m_denied = (host_req && !hg) ? ((m_denied < HM) ? m_denied + 1 : HM) : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(1, 0, 8'h01, '0, 1, 0, 8'h02, '0);
        @(negedge clk);
        n_vec++;
        if ({core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, starve} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, starve});
        end
        tick();
        tick();
        reset = 0;
        idle();
        @(negedge clk);
        n_vec++;
        if ({core_rdata, host_rdata, mem_en} !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: core %h host %h en %b expected 00 00 0", core_rdata, host_rdata, mem_en);
        end
        tick();
    endtask

    task automatic test_core_read();
        poke(8'h05, 8'h3C);
        drive(1, 0, 8'h05, '0, 0, 0, '0, '0);
        @(negedge clk);
        n_vec++;
        if ({core_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 8'h05}) begin
            n_err++;
            $display("FAIL core_read_gnt: gnt %b en %b we %b addr %h expected 1 1 0 05", core_gnt, mem_en, mem_we, mem_addr);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if ({core_rvalid, core_rdata, host_rvalid} !== {1'b1, 8'h3C, 1'b0}) begin
            n_err++;
            $display("FAIL core_read_data: rvalid %b rdata %h host_rvalid %b expected 1 3c 0", core_rvalid, core_rdata, host_rvalid);
        end
        tick();
    endtask

    task automatic test_starve();
        drive(1, 0, 8'h01, '0, 1, 0, 8'h02, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if ({host_gnt, core_gnt, starve} !== ((i % 5 == 4) ? 3'b101 : 3'b010)) begin
                n_err++;
                $display("FAIL starve_pattern cycle %0d: hgnt/cgnt/starve %b expected %b", i,
                         {host_gnt, core_gnt, starve}, (i % 5 == 4) ? 3'b101 : 3'b010);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_host_wr_rd();
        drive(0, 0, '0, '0, 1, 1, 8'h10, 8'hA5);
        @(negedge clk);
        n_vec++;
        if ({host_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h10, 8'hA5}) begin
            n_err++;
            $display("FAIL host_write: gnt %b we %b addr %h wdata %h expected 1 1 10 a5", host_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        drive(0, 0, '0, '0, 1, 0, 8'h10, '0);
        @(negedge clk);
        n_vec++;
        if ({host_gnt, host_rvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL host_read_gnt: gnt %b rvalid %b expected 1 0", host_gnt, host_rvalid);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if ({host_rvalid, host_rdata, core_rvalid} !== {1'b1, 8'hA5, 1'b0}) begin
            n_err++;
            $display("FAIL host_read_data: rvalid %b rdata %h core_rvalid %b expected 1 a5 0", host_rvalid, host_rdata, core_rvalid);
        end
        tick();
    endtask

    task automatic test_core_wrap();
        poke(8'h00, 8'h11);
        drive(1, 1, 8'hFF, 8'h7F, 0, 0, '0, '0);
        tick();
        drive(1, 0, 8'hFF, '0, 0, 0, '0, '0);
        @(negedge clk);
        n_vec++;
        if ({core_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL wrap_read_ff_issue: gnt %b we %b addr %h expected 1 0 ff", core_gnt, mem_we, mem_addr);
        end
        tick();
        drive(1, 0, 8'h00, '0, 0, 0, '0, '0);
        @(negedge clk);
        n_vec++;
        if ({core_rvalid, core_rdata, core_gnt} !== {1'b1, 8'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_read_ff_data: rvalid %b rdata %h gnt %b expected 1 7f 1", core_rvalid, core_rdata, core_gnt);
        end
        tick();
        idle();
        @(negedge clk);
        n_vec++;
        if ({core_rvalid, core_rdata} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL wrap_read_00_data: rvalid %b rdata %h expected 1 11", core_rvalid, core_rdata);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({core_rvalid, core_rdata} !== {1'b0, 8'h11}) begin
            n_err++;
            $display("FAIL rdata_hold: rvalid %b rdata %h expected 0 11", core_rvalid, core_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(0, 0, '0, '0, 1, 0, 8'h10, '0);
        tick();
        idle();
        reset = 1;
        @(negedge clk);
        n_vec++;
        if (host_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_read_during: host_rvalid %b expected 0", host_rvalid);
        end
        tick();
        reset = 0;
        @(negedge clk);
        n_vec++;
        if ({host_rvalid, host_rdata} !== {1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_mid_read_after: rvalid %b rdata %h expected 0 00", host_rvalid, host_rdata);
        end
        tick();
        drive(1, 0, 8'h03, '0, 1, 0, 8'h04, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (host_gnt !== (i == 4)) begin
                n_err++;
                $display("FAIL reset_wait_cleared cycle %0d: host_gnt %b expected %b", i, host_gnt, i == 4);
            end
            tick();
        end
        idle();
        tick();
        n_vec++;
        if (ram[8'h10] !== 8'hA5) begin
            n_err++;
            $display("FAIL reset_ram_kept: ram[10] %h expected a5", ram[8'h10]);
        end
    endtask

    task automatic test_host_pulse();
        drive(1, 0, 8'h07, '0, 1, 0, 8'h08, '0);
        @(negedge clk);
        n_vec++;
        if ({host_gnt, core_gnt} !== 2'b01) begin
            n_err++;
            $display("FAIL host_pulse_denied: hgnt/cgnt %b expected 01", {host_gnt, core_gnt});
        end
        tick();
        drive(1, 0, 8'h07, '0, 0, 0, '0, '0);
        tick();
        tick();
        drive(1, 0, 8'h07, '0, 1, 0, 8'h08, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (host_gnt !== (i == 4)) begin
                n_err++;
                $display("FAIL host_pulse_wait_cleared cycle %0d: host_gnt %b expected %b", i, host_gnt, i == 4);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        bit           hg, cg, ewe;
        logic [M-1:0] ea;
        logic [W-1:0] ed;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, M'($urandom_range(0, 7)), W'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, M'($urandom_range(0, 7)), W'($urandom));
            hg  = exp_hg();
            cg  = exp_cg();
            ewe = hg ? host_we : cg ? core_we : 1'b0;
            ea  = hg ? host_addr : cg ? core_addr : '0;
            ed  = hg ? host_wdata : cg ? core_wdata : '0;
            @(negedge clk);
            n_vec++;
            if ({host_gnt, core_gnt, starve, mem_en, mem_we, mem_addr, mem_wdata} !==
                {hg, cg, !reset && host_req && m_denied >= HM, hg || cg, ewe, ea, ed}) begin
                n_err++;
                $display("FAIL rand_grant cycle %0d: h/c/st/en/we %b%b%b%b%b addr %h wd %h expected %b%b%b%b%b %h %h", i,
                         host_gnt, core_gnt, starve, mem_en, mem_we, mem_addr, mem_wdata,
                         hg, cg, !reset && host_req && m_denied >= HM, hg || cg, ewe, ea, ed);
            end
            n_vec++;
            if ({core_rvalid, host_rvalid, core_rdata, host_rdata} !==
                {m_pc && !reset, m_ph && !reset, (m_pc && !reset) ? m_pd : m_lc, (m_ph && !reset) ? m_pd : m_lh}) begin
                n_err++;
                $display("FAIL rand_read cycle %0d: crv %b hrv %b crd %h hrd %h expected %b %b %h %h", i,
                         core_rvalid, host_rvalid, core_rdata, host_rdata, m_pc && !reset, m_ph && !reset,
                         (m_pc && !reset) ? m_pd : m_lc, (m_ph && !reset) ? m_pd : m_lh);
            end
            tick();
        end
        reset = 0;
        idle();
        tick();
    endtask

    initial begin
        for (int a = 0; a < 2**M; a++) poke(M'(a), W'($urandom));
        m_denied = 0; m_pc = 0; m_ph = 0; m_pd = '0; m_lc = '0; m_lh = '0;
        reset = 1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_core_read();
        test_starve();
        test_host_wr_rd();
        test_core_wrap();
        test_reset_mid_read();
        test_host_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
